// File: rtl/ram_data_mp_if.sv
// Bus bundle between NUM_CORES requesting cores and the shared data RAM.
//
// Handshake: a core raises REQ[i] with WR[i], its ADDBUS slice and, for a
// write, its DATAIN slice, and holds them all stable until GNT[i] pulses for
// one cycle. In that GNT cycle DATAOUT carries the read word and ERR flags
// an out-of-range address. The core then drops REQ[i] or presents a new
// request; a new request is not served at the edge that ends the GNT cycle.
interface ram_data_mp_if #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
);
    logic [NUM_CORES-1:0]        REQ;
    logic [NUM_CORES-1:0]        WR;
    logic [NUM_CORES*ADDR_W-1:0] ADDBUS;
    logic [NUM_CORES*DATA_W-1:0] DATAIN;
    logic [NUM_CORES-1:0]        GNT;
    logic [DATA_W-1:0]           DATAOUT;
    logic                        ERR;

    modport master (
        output REQ, WR, ADDBUS, DATAIN,
        input  GNT, DATAOUT, ERR
    );

    modport slave (
        input  REQ, WR, ADDBUS, DATAIN,
        output GNT, DATAOUT, ERR
    );
endinterface

// File: rtl/ram_data_mp.sv
// Multi-port data RAM: NUM_CORES cores share one single-port array through
// a round-robin arbiter serving one access per cycle. A granted access
// completes one cycle after its selection edge with a one-hot GNT pulse.
module ram_data_mp #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1024
) (
    input logic          clk,
    input logic          rst,
    ram_data_mp_if.slave bus
);
    localparam int               IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int               MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CORES - 1);
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    // Power-up image: words 0 and 1 hold fixed constants; the array is never
    // cleared by rst so contents survive a reset.
    logic [DATA_W-1:0] mem [DEPTH] = '{0: DATA_W'(10), 1: DATA_W'(12), default: '0};

    logic [NUM_CORES-1:0] gnt_q;
    logic [DATA_W-1:0]    dout_q;
    logic                 err_q;
    logic [IDX_W-1:0]     last_grant;

    logic [NUM_CORES-1:0] eligible;
    logic                 found;
    logic [IDX_W-1:0]     sel;
    int                   rr_idx;
    logic                 sel_wr;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic                 in_range;
    logic [MEM_AW-1:0]    mem_idx;

    // A core sitting in its GNT cycle is not eligible, so a held REQ cannot
    // be served twice back to back.
    assign eligible = bus.REQ & ~gnt_q;

    // Round-robin pick: search upward from the core after the last grant.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_idx = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            rr_idx = (int'(last_grant) + k) % NUM_CORES;
            if (!found && eligible[rr_idx]) begin
                found = 1'b1;
                sel   = IDX_W'(rr_idx);
            end
        end
    end

    // Route the selected core's operation, address and write data.
    always_comb begin
        sel_wr   = bus.WR[sel];
        sel_addr = bus.ADDBUS[int'(sel)*ADDR_W +: ADDR_W];
        sel_data = bus.DATAIN[int'(sel)*DATA_W +: DATA_W];
    end

    assign in_range = ({1'b0, sel_addr} < DEPTH_L);
    assign mem_idx  = sel_addr[MEM_AW-1:0];

    // Arbitration state and the registered one-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= '0;
            dout_q     <= '0;
            err_q      <= 1'b0;
            last_grant <= LAST_RST;
        end else begin
            gnt_q  <= '0;
            dout_q <= '0;
            err_q  <= 1'b0;
            if (found) begin
                gnt_q[sel] <= 1'b1;
                last_grant <= sel;
                err_q      <= ~in_range;
                if (!sel_wr && in_range) begin
                    dout_q <= mem[mem_idx];
                end
            end
        end
    end

    // Write port: only a selected, in-range write outside reset updates the array.
    always_ff @(posedge clk) begin
        if (!rst && found && sel_wr && in_range) begin
            mem[mem_idx] <= sel_data;
        end
    end

    assign bus.GNT     = gnt_q;
    assign bus.DATAOUT = dout_q;
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_ram_data_mp.sv
// Bench for ram_data_mp: directed accesses with literal expectations plus a
// cycle-by-cycle comparison against a behavioural model of the shared RAM.
module tb_ram_data_mp;
    localparam int NC    = 4;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_data_mp_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_data_mp #(
        .NUM_CORES(NC),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    // Entry layout: {gnt[3:0], dataout[15:0], err, dataout_checked}
    logic [21:0]   exp_q[$];
    logic [21:0]   m_ent;
    logic [DW-1:0] m_mem [DEPTH];
    int            m_last;
    logic [NC-1:0] m_gnt;
    int            m_sel;
    int            m_i;
    int            m_addr;
    logic [DW-1:0] m_d;
    logic          m_e;
    logic          m_dc;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_mem[0] = 16'd10;
        m_mem[1] = 16'd12;
        m_last   = NC - 1;
        m_gnt    = '0;
    end

    // At each edge decide which core is served and what it must see next cycle.
    always @(posedge clk) begin
        m_sel = -1;
        m_d   = '0;
        m_e   = 1'b0;
        m_dc  = 1'b1;
        if (rst) begin
            m_last = NC - 1;
            m_gnt  = '0;
        end else begin
            for (int k = 1; k <= NC; k++) begin
                m_i = (m_last + k) % NC;
                if (m_sel < 0 && bus.REQ[m_i] && !m_gnt[m_i]) m_sel = m_i;
            end
            m_gnt = '0;
            if (m_sel >= 0) begin
                m_gnt[m_sel] = 1'b1;
                m_last       = m_sel;
                m_addr       = int'(bus.ADDBUS[m_sel*AW +: AW]);
                if (bus.WR[m_sel]) m_dc = 1'b0;
                if (m_addr >= DEPTH) m_e = 1'b1;
                else if (bus.WR[m_sel]) m_mem[m_addr] = bus.DATAIN[m_sel*DW +: DW];
                else m_d = m_mem[m_addr];
            end
        end
        exp_q.push_back({m_gnt, m_d, m_e, m_dc});
    end

    // Compare DUT outputs with the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=none required=entry at %0t", $time);
        end else begin
            m_ent = exp_q.pop_front();
            check("model_gnt", 32'(bus.GNT), 32'(m_ent[21:18]));
            check("model_err", 32'(bus.ERR), 32'(m_ent[1]));
            if (m_ent[0]) check("model_dataout", 32'(bus.DATAOUT), 32'(m_ent[17:2]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic access(input int core, input bit wr, input int addr, input logic [DW-1:0] data,
                          output logic [DW-1:0] dout, output logic err, output int lat);
        bit done;
        @(negedge clk);
        bus.REQ[core]               = 1'b1;
        bus.WR[core]                = wr;
        bus.ADDBUS[core*AW +: AW]   = AW'(addr);
        bus.DATAIN[core*DW +: DW]   = data;
        done = 1'b0;
        lat  = 0;
        dout = '0;
        err  = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            lat++;
            if (bus.GNT[core]) begin
                dout = bus.DATAOUT;
                err  = bus.ERR;
                done = 1'b1;
            end
        end
        bus.REQ[core] = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout core=%0d actual=no_gnt required=gnt", core);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [DW-1:0] d;
        logic          e;
        int            lat;

        bus.REQ    = '0;
        bus.WR     = '0;
        bus.ADDBUS = '0;
        bus.DATAIN = '0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_gnt", 32'(bus.GNT), 32'h0);
        check("reset_dataout", 32'(bus.DATAOUT), 32'h0);
        check("reset_err", 32'(bus.ERR), 32'h0);
        rst = 1'b0;

        // Initial image and one-cycle read latency
        access(0, 1'b0, 0, 16'h0, d, e, lat);
        check("rd0_data", 32'(d), 32'd10);
        check("rd0_err", 32'(e), 32'd0);
        check("rd0_latency", 32'(lat), 32'd1);
        access(0, 1'b0, 1, 16'h0, d, e, lat);
        check("rd1_data", 32'(d), 32'd12);

        // Write then read back through core 1
        access(1, 1'b1, 5, 16'h1234, d, e, lat);
        check("wr5_err", 32'(e), 32'd0);
        access(1, 1'b0, 5, 16'h0, d, e, lat);
        check("rd5_data", 32'(d), 32'h1234);

        // Continuous requests from every core after a fresh reset
        @(negedge clk);
        do_reset(2);
        bus.WR     = '0;
        bus.ADDBUS = {16'd0, 16'd1, 16'd5, 16'd0};
        bus.REQ    = '1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("rr_order", 32'(bus.GNT), 32'(1) << (n % NC));
        end
        bus.REQ = '0;

        // Out-of-range write and read
        access(2, 1'b1, 1024, 16'hBEEF, d, e, lat);
        check("oor_wr_err", 32'(e), 32'd1);
        access(2, 1'b0, 1024, 16'h0, d, e, lat);
        check("oor_rd_data", 32'(d), 32'd0);
        check("oor_rd_err", 32'(e), 32'd1);
        access(2, 1'b0, 0, 16'h0, d, e, lat);
        check("oor_mem0_intact", 32'(d), 32'd10);

        // Requests during reset are dropped; core 0 wins first after release
        @(negedge clk);
        rst        = 1'b1;
        bus.REQ    = 4'b1001;
        bus.WR     = 4'b1001;
        bus.ADDBUS = {16'd0, 16'd0, 16'd0, 16'd1};
        bus.DATAIN = {16'hBEEF, 16'h0, 16'h0, 16'hDEAD};
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rst_req_gnt", 32'(bus.GNT), 32'h0);
        end
        rst        = 1'b0;
        bus.ADDBUS = {16'd8, 16'd0, 16'd0, 16'd7};
        bus.DATAIN = {16'h8888, 16'h0, 16'h0, 16'h7777};
        @(negedge clk);
        check("post_rst_first", 32'(bus.GNT), 32'h1);
        bus.REQ[0] = 1'b0;
        @(negedge clk);
        check("post_rst_second", 32'(bus.GNT), 32'h8);
        bus.REQ[3] = 1'b0;
        bus.WR     = '0;
        access(1, 1'b0, 1, 16'h0, d, e, lat);
        check("rst_mem1_intact", 32'(d), 32'd12);
        access(1, 1'b0, 0, 16'h0, d, e, lat);
        check("rst_mem0_intact", 32'(d), 32'd10);
        access(2, 1'b0, 7, 16'h0, d, e, lat);
        check("post_rst_wr7", 32'(d), 32'h7777);
        access(3, 1'b0, 8, 16'h0, d, e, lat);
        check("post_rst_wr8", 32'(d), 32'h8888);

        // Lone core holding REQ through its GNT is served every other cycle
        @(negedge clk);
        bus.WR[0]          = 1'b0;
        bus.ADDBUS[0 +: AW] = 16'd1;
        bus.REQ[0]         = 1'b1;
        @(negedge clk);
        check("hold_gnt_a", 32'(bus.GNT), 32'h1);
        check("hold_data_a", 32'(bus.DATAOUT), 32'd12);
        @(negedge clk);
        check("hold_gap", 32'(bus.GNT), 32'h0);
        @(negedge clk);
        check("hold_gnt_b", 32'(bus.GNT), 32'h1);
        bus.REQ = '0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_data_mp.md
RAM_DATA_MP -- requirements
Module: ram_data_mp

Interface
REQ-001 Parameter NUM_CORES, default 4: number of requesting cores (1..8).
REQ-002 Parameter DATA_W, default 16: word width in bits.
REQ-003 Parameter ADDR_W, default 16: address width per core.
REQ-004 Parameter DEPTH, default 1024: number of words, with DEPTH <= 2^ADDR_W.
REQ-005 Port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port REQ, input, NUM_CORES: per-core access request, held until that core's GNT pulse.
REQ-008 Port WR, input, NUM_CORES: per-core operation select (1 = write, 0 = read), valid while REQ is high.
REQ-009 Port ADDBUS, input, NUM_CORES*ADDR_W: per-core word address; core i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 Port DATAIN, input, NUM_CORES*DATA_W: per-core write data, sliced the same way as ADDBUS.
REQ-011 Port GNT, output, NUM_CORES: one-cycle per-core completion pulse.
REQ-012 Port DATAOUT, output, DATA_W: shared read data, valid only while a GNT bit is high for a read.
REQ-013 Port ERR, output, 1: out-of-range flag, pulsed with GNT.

Function
REQ-014 Storage shall be a DEPTH x DATA_W array; it shall not be cleared by rst; initial contents shall be mem[0]=10, mem[1]=12, all other words undefined.
REQ-015 At each rising edge, when not in reset, the arbiter shall select at most one eligible core, where eligible means REQ[i]=1 and GNT[i] is not high in the current cycle.
REQ-016 Selection shall be round-robin: search from index (last_grant+1) mod NUM_CORES upward and wrap around; last_grant shall reset to NUM_CORES-1, so core 0 has first priority.
REQ-017 A selected write with in-range address shall update mem[addr] with DATAIN at that edge.
REQ-018 A selected read shall register mem[addr] into DATAOUT at that edge; read latency is one cycle from the selection edge to GNT.
REQ-019 In the cycle after selection, GNT[sel] shall be 1 and all other GNT bits 0; GNT shall be one-hot or all-zero in every cycle.
REQ-020 When no core is selected, GNT shall be 0, DATAOUT shall hold 0, and ERR shall be 0.
REQ-021 An address >= DEPTH shall produce no memory write, DATAOUT = 0, and ERR = 1 during the GNT cycle; the grant still completes.
REQ-022 The requester shall deassert REQ, or present a new request, in its GNT cycle; because of REQ-015 it cannot be re-selected at the edge ending its GNT cycle.
REQ-023 The write data of a write selected at edge k shall be visible to a read selected at edge k+1 or later.
REQ-024 Throughput shall be one access per cycle whenever any eligible request exists.
REQ-025 REQ deasserted before GNT (a protocol violation) shall cause no memory effect unless the request was already selected.

Reset
REQ-026 While rst=1 at an edge: GNT=0, DATAOUT=0, ERR=0, last_grant=NUM_CORES-1, and no memory write occurs even if REQ and WR are high.
REQ-027 A request pending when rst asserts shall be dropped and no GNT issued for it; the requester shall re-issue it after reset.
REQ-028 The first edge with rst=0 shall perform normal arbitration.

Verification
REQ-029 After reset, core 0 reads addr 0 -> GNT=0001 one cycle later, DATAOUT=10, ERR=0.
REQ-030 Core 1 writes 0x1234 to addr 5, then reads addr 5 -> GNT[1] twice, with DATAOUT=0x1234 on the second.
REQ-031 All four cores request continuously -> grant order 0,1,2,3,0,..., each GNT one cycle wide, one grant per cycle, no core starved.
REQ-032 Core 2 writes 0xBEEF to addr 1024 -> GNT[2] with ERR=1; a subsequent read of addr 1024 returns 0 with ERR=1; memory contents unchanged.
REQ-033 rst asserted while cores 0 and 3 request writes -> no GNT and no memory change during reset; after release core 0 is granted first.
REQ-034 Core 0 holds REQ through its GNT cycle -> not re-selected at that edge; any other requester is selected instead, and if none, core 0 is re-granted one cycle later.
